cpu6_ifetch: RTL and testbench

- Instruction-fetch stage directly upstream of the cpu6 EX/MEM/WB datapath.
- Owns the fetch PC and issues in-order word requests to instruction memory over a valid/ready request channel, with a separate response channel.
- Buffers returned instructions with their PCs in a small FIFO and presents pcE/instrE/validE to the datapath.
- Redirects on taken branch/jump (pcsrcE/pcnextE) or trap/mret (redirect_excp/redirect_excp_pc), discarding all wrong-path fetches.

---
 rtl/cpu6_ifetch.sv | 126 ++++++++++++
 tb/tb_cpu6_ifetch.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu6_ifetch.sv
// cpu6 instruction-fetch stage: owns the fetch PC and issues in-order word requests.
// Returned words are buffered with their PCs and presented to EX as pcE/instrE/validE.
// On a redirect, the stage flushes the FIFO and discards the responses still in flight.
module cpu6_ifetch #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_instr,
  input  logic            stallE,
  input  logic            pcsrcE,
  input  logic [XLEN-1:0] pcnextE,
  input  logic            redirect_excp,
  input  logic [XLEN-1:0] redirect_excp_pc,
  input  logic            halt,
  output logic            validE,
  output logic [XLEN-1:0] pcE,
  output logic [XLEN-1:0] instrE,
  output logic            idle
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   drop;
  logic [CW-1:0]   count;
  logic [AW-1:0]   aq_rd;
  logic [AW-1:0]   aq_wr;
  logic [AW-1:0]   fq_rd;
  logic [AW-1:0]   fq_wr;
  logic [XLEN-1:0] aq_mem  [DEPTH];
  logic [XLEN-1:0] pc_mem  [DEPTH];
  logic [XLEN-1:0] ins_mem [DEPTH];

  logic            redir;
  logic            rsp;
  logic            keep;
  logic            pop;
  logic            accept;
  logic [XLEN-1:0] target;
  logic [CW:0]     used;

  // Issue credit, redirect target, and output presentation.
  // A FIFO slot being popped this cycle is counted as free, so DEPTH=2 sustains one per cycle.
  always_comb begin
    redir          = redirect_excp | pcsrcE;
    target         = redirect_excp ? redirect_excp_pc : pcnextE;
    target[1:0]    = 2'b00;
    validE         = (count != '0);
    pop            = validE & ~stallE & ~redir;
    rsp            = imem_rsp_valid & (inflight != '0);
    keep           = rsp & (drop == '0) & ~redir;
    used           = (CW+1)'(inflight) + (CW+1)'(count) - (CW+1)'(pop);
    imem_req_valid = reset & ~halt & ~redir & (used < (CW+1)'(DEPTH));
    accept         = imem_req_valid & imem_req_ready;
    imem_req_addr  = fetch_pc;
    pcE            = validE ? pc_mem[fq_rd] : '0;
    instrE         = validE ? ins_mem[fq_rd] : '0;
    idle           = (inflight == '0) & (count == '0);
  end

  // Control state: fetch PC, in-flight and drop counters, queue pointers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= {RESET_PC[XLEN-1:2], 2'b00};
      inflight <= '0;
      drop     <= '0;
      count    <= '0;
      aq_rd    <= '0;
      aq_wr    <= '0;
      fq_rd    <= '0;
      fq_wr    <= '0;
    end else begin
      if (redir) begin
        fetch_pc <= target;
      end else if (accept) begin
        fetch_pc <= fetch_pc + XLEN'(4);
      end
      if (accept) begin
        aq_wr <= aq_wr + AW'(1);
      end
      if (rsp) begin
        aq_rd <= aq_rd + AW'(1);
      end
      inflight <= inflight + CW'(accept) - CW'(rsp);
      if (redir) begin
        drop <= inflight - CW'(rsp);
      end else if (rsp && (drop != '0)) begin
        drop <= drop - CW'(1);
      end
      if (redir) begin
        count <= '0;
        fq_rd <= '0;
        fq_wr <= '0;
      end else begin
        if (keep) begin
          fq_wr <= fq_wr + AW'(1);
        end
        if (pop) begin
          fq_rd <= fq_rd + AW'(1);
        end
        count <= count + CW'(keep) - CW'(pop);
      end
    end
  end

  // Storage for the address queue and the instruction FIFO.
  always_ff @(posedge clk) begin
    if (accept) begin
      aq_mem[aq_wr] <= fetch_pc;
    end
    if (keep) begin
      pc_mem[fq_wr]  <= aq_mem[aq_rd];
      ins_mem[fq_wr] <= imem_rsp_instr;
    end
  end

endmodule

// File: tb/tb_cpu6_ifetch.sv
// Directed bench for cpu6_ifetch with a small in-order instruction-memory model.
module tb_cpu6_ifetch;

  logic        clk;
  logic        reset;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_instr;
  logic        stallE;
  logic        pcsrcE;
  logic [31:0] pcnextE;
  logic        redirect_excp;
  logic [31:0] redirect_excp_pc;
  logic        halt;
  logic        validE;
  logic [31:0] pcE;
  logic [31:0] instrE;
  logic        idle;

  int          total;
  int          passed;
  logic [31:0] pend[$];
  bit          hold;

  cpu6_ifetch dut (
    .clk              (clk),
    .reset            (reset),
    .imem_req_valid   (imem_req_valid),
    .imem_req_addr    (imem_req_addr),
    .imem_req_ready   (imem_req_ready),
    .imem_rsp_valid   (imem_rsp_valid),
    .imem_rsp_instr   (imem_rsp_instr),
    .stallE           (stallE),
    .pcsrcE           (pcsrcE),
    .pcnextE          (pcnextE),
    .redirect_excp    (redirect_excp),
    .redirect_excp_pc (redirect_excp_pc),
    .halt             (halt),
    .validE           (validE),
    .pcE              (pcE),
    .instrE           (instrE),
    .idle             (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory image: each word is its address XOR a fixed pattern.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5C3_0F00;
  endfunction

  // One clock: sample handshakes at negedge, then model a 1-cycle in-order memory.
  task automatic step();
    logic        acc;
    logic        rf;
    logic [31:0] a;
    @(negedge clk);
    acc = imem_req_valid & imem_req_ready;
    a   = imem_req_addr;
    rf  = imem_rsp_valid;
    @(posedge clk);
    #1;
    if (rf && pend.size() > 0) void'(pend.pop_front());
    if (acc) pend.push_back(a);
    if (!hold && pend.size() > 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_instr = mem_word(pend[0]);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_instr = '0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_instr = '0;
    stallE = 1'b0; pcsrcE = 1'b0; pcnextE = '0; redirect_excp = 1'b0;
    redirect_excp_pc = '0; halt = 1'b0; hold = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    total++; if (validE !== 1'b0) $display("FAIL reset_validE got=%0b exp=0", validE); else passed++;
    total++; if (pcE !== 32'h0) $display("FAIL reset_pcE got=%h exp=0", pcE); else passed++;
    total++; if (instrE !== 32'h0) $display("FAIL reset_instrE got=%h exp=0", instrE); else passed++;
    total++; if (idle !== 1'b1) $display("FAIL reset_idle got=%0b exp=1", idle); else passed++;
    total++; if (imem_req_valid !== 1'b0) $display("FAIL reset_req_valid got=%0b exp=0", imem_req_valid); else passed++;
  endtask

  task automatic test_stream();
    reset = 1'b1; #1;
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0)
      $display("FAIL stream_first_req got=%0b/%h exp=1/00000000", imem_req_valid, imem_req_addr); else passed++;
    step();
    total++; if (validE !== 1'b0 || imem_req_addr !== 32'h4)
      $display("FAIL stream_second_req got=%0b/%h exp=0/00000004", validE, imem_req_addr); else passed++;
    step();
    total++; if (validE !== 1'b1 || pcE !== 32'h0 || instrE !== mem_word(32'h0))
      $display("FAIL stream_first_out got=%0b/%h/%h exp=1/00000000/%h", validE, pcE, instrE, mem_word(32'h0)); else passed++;
    for (int i = 1; i <= 6; i++) begin
      step();
      total++; if (validE !== 1'b1 || pcE !== 32'(4 * i) || instrE !== mem_word(32'(4 * i)))
        $display("FAIL stream_pc%0d got=%0b/%h/%h exp=1/%h", i, validE, pcE, instrE, 32'(4 * i)); else passed++;
    end
  endtask

  task automatic test_stall();
    stallE = 1'b1; #1;
    total++; if (imem_req_valid !== 1'b0) $display("FAIL stall_req_blocked got=%0b exp=0", imem_req_valid); else passed++;
    for (int i = 0; i < 5; i++) begin
      step();
      total++; if (validE !== 1'b1 || pcE !== 32'h18 || instrE !== mem_word(32'h18) || imem_req_valid !== 1'b0)
        $display("FAIL stall_hold%0d got=%0b/%h/%h/%0b exp=1/00000018/%h/0", i, validE, pcE, instrE, imem_req_valid, mem_word(32'h18)); else passed++;
    end
    stallE = 1'b0; #1;
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h20)
      $display("FAIL stall_release_req got=%0b/%h exp=1/00000020", imem_req_valid, imem_req_addr); else passed++;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (validE !== 1'b1 || pcE !== 32'(28 + 4 * i) || instrE !== mem_word(32'(28 + 4 * i)))
        $display("FAIL stall_resume%0d got=%0b/%h exp=1/%h", i, validE, pcE, 32'(28 + 4 * i)); else passed++;
    end
  endtask

  task automatic test_branch_redirect();
    imem_rsp_valid = 1'b0; hold = 1'b1;
    pcsrcE = 1'b1; pcnextE = 32'h102; #1;
    total++; if (imem_req_valid !== 1'b0) $display("FAIL br_no_issue got=%0b exp=0", imem_req_valid); else passed++;
    step();
    pcsrcE = 1'b0; hold = 1'b0; #1;
    total++; if (validE !== 1'b0) $display("FAIL br_flush got=%0b exp=0", validE); else passed++;
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100)
      $display("FAIL br_target_req got=%0b/%h exp=1/00000100", imem_req_valid, imem_req_addr); else passed++;
    step();
    step();
    total++; if (validE !== 1'b0) $display("FAIL br_old_dropped got=%0b/%h exp=0", validE, pcE); else passed++;
    step();
    total++; if (validE !== 1'b1 || pcE !== 32'h100 || instrE !== mem_word(32'h100))
      $display("FAIL br_first_out got=%0b/%h/%h exp=1/00000100/%h", validE, pcE, instrE, mem_word(32'h100)); else passed++;
  endtask

  task automatic test_excp_priority();
    redirect_excp = 1'b1; redirect_excp_pc = 32'h80; pcsrcE = 1'b1; pcnextE = 32'h200;
    step();
    redirect_excp = 1'b0; pcsrcE = 1'b0; #1;
    total++; if (idle !== 1'b1 || validE !== 1'b0) $display("FAIL ex_idle got=%0b/%0b exp=1/0", idle, validE); else passed++;
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h80)
      $display("FAIL ex_priority_req got=%0b/%h exp=1/00000080", imem_req_valid, imem_req_addr); else passed++;
    step();
    step();
    total++; if (validE !== 1'b1 || pcE !== 32'h80 || instrE !== mem_word(32'h80))
      $display("FAIL ex_first_out got=%0b/%h exp=1/00000080", validE, pcE); else passed++;
  endtask

  task automatic test_redirect_with_rsp();
    imem_rsp_valid = 1'b0; hold = 1'b1;
    step();
    total++; if (validE !== 1'b0 || imem_req_valid !== 1'b0 || idle !== 1'b0)
      $display("FAIL rr_two_inflight got=%0b/%0b/%0b exp=0/0/0", validE, imem_req_valid, idle); else passed++;
    imem_rsp_valid = 1'b1; imem_rsp_instr = mem_word(pend[0]); hold = 1'b0;
    pcsrcE = 1'b1; pcnextE = 32'h40;
    step();
    pcsrcE = 1'b0; #1;
    total++; if (validE !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h40)
      $display("FAIL rr_target_req got=%0b/%0b/%h exp=0/1/00000040", validE, imem_req_valid, imem_req_addr); else passed++;
    step();
    total++; if (validE !== 1'b0) $display("FAIL rr_second_dropped got=%0b/%h exp=0", validE, pcE); else passed++;
    step();
    total++; if (validE !== 1'b1 || pcE !== 32'h40 || instrE !== mem_word(32'h40))
      $display("FAIL rr_first_out got=%0b/%h/%h exp=1/00000040/%h", validE, pcE, instrE, mem_word(32'h40)); else passed++;
  endtask

  task automatic test_halt_and_reset();
    imem_rsp_valid = 1'b0; hold = 1'b1;
    step();
    halt = 1'b1; hold = 1'b0; #1;
    total++; if (imem_req_valid !== 1'b0 || idle !== 1'b0)
      $display("FAIL halt_blocked got=%0b/%0b exp=0/0", imem_req_valid, idle); else passed++;
    step();
    step();
    total++; if (validE !== 1'b1 || pcE !== 32'h44 || imem_req_valid !== 1'b0)
      $display("FAIL halt_first got=%0b/%h/%0b exp=1/00000044/0", validE, pcE, imem_req_valid); else passed++;
    step();
    total++; if (validE !== 1'b1 || pcE !== 32'h48 || instrE !== mem_word(32'h48) || idle !== 1'b0)
      $display("FAIL halt_second got=%0b/%h/%0b exp=1/00000048/0", validE, pcE, idle); else passed++;
    step();
    total++; if (validE !== 1'b0 || idle !== 1'b1 || imem_req_valid !== 1'b0)
      $display("FAIL halt_idle got=%0b/%0b/%0b exp=0/1/0", validE, idle, imem_req_valid); else passed++;
    halt = 1'b0; #1;
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4c)
      $display("FAIL halt_resume got=%0b/%h exp=1/0000004c", imem_req_valid, imem_req_addr); else passed++;
    step();
    step();
    total++; if (validE !== 1'b1 || pcE !== 32'h4c)
      $display("FAIL pre_reset_out got=%0b/%h exp=1/0000004c", validE, pcE); else passed++;
    #2 reset = 1'b0; #1;
    total++; if (validE !== 1'b0 || pcE !== 32'h0 || instrE !== 32'h0 || idle !== 1'b1 || imem_req_valid !== 1'b0)
      $display("FAIL async_reset got=%0b/%h/%h/%0b/%0b exp=0/0/0/1/0", validE, pcE, instrE, idle, imem_req_valid); else passed++;
    pend.delete(); imem_rsp_valid = 1'b0;
    step();
    step();
    reset = 1'b1; #1;
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0)
      $display("FAIL reset_restart got=%0b/%h exp=1/00000000", imem_req_valid, imem_req_addr); else passed++;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    test_reset();
    test_stream();
    test_stall();
    test_branch_redirect();
    test_excp_priority();
    test_redirect_with_rsp();
    test_halt_and_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
